instr_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the main control decoder and the register/immediate path.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared widths, opcode constants and the fetch buffer entry type.
// Rev    : 1.0
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous FIFO of fetch entries with flush and combinational head.
// Rev    : 1.0
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, push and pop hit the same slot: the head is read before the write lands.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign count = r_count;
  assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Brief  : PC, credit-limited in-order fetch requests, response buffering and
//          redirect flush feeding decode through a valid/ready handshake.
// Rev    : 1.0
// ============================================================================
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode
);

  localparam int              CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]  c_depth    = (CNT_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0] c_pc_step  = XLEN'(4);
  localparam logic [XLEN-1:0] c_reset_pc = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_credit_used;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_req_fire;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

  // Outstanding requests plus buffered entries never exceed DEPTH, so pushes cannot overflow.
  assign imem_req_valid = reset_n && !redirect_valid && (w_credit_used < c_depth);
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push             = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
  assign w_push_entry.instr = imem_rsp_data;
  assign w_push_entry.pc    = r_rsp_pc;

  assign if_valid = reset_n && (w_fifo_count != '0) && !redirect_valid;
  assign w_pop    = if_valid && if_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= c_reset_pc;
      r_rsp_pc      <= c_reset_pc;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        // Everything still in flight belongs to the abandoned path.
        r_pc       <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= r_outstanding - CNT_W'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc <= r_pc + c_pc_step;
        if (w_push)     r_rsp_pc <= r_rsp_pc + c_pc_step;
        if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      case ({w_req_fire, imem_rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  a_rsp_needs_credit: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid |-> (r_outstanding != '0));

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc;
  assign if_opcode = w_head.instr[6:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Self-checking bench for instr_fetch_unit against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_ready = 1'b0;

  logic        imem_req_valid, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic [6:0]  if_opcode;
  logic        wr_req_valid, wr_if_valid;
  logic [31:0] wr_addr, wr_if_instr, wr_if_pc;
  logic [6:0]  wr_if_opcode;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_opcode(if_opcode)
  );

  // Same stimulus as dut; only the reset PC differs, so credit behaviour is identical.
  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(wr_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(wr_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(wr_if_valid), .if_ready(if_ready), .if_instr(wr_if_instr), .if_pc(wr_if_pc),
    .if_opcode(wr_if_opcode)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        m_inflight[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc, m_wpc;
  int          m_epoch = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_extra = 0;
  logic        e_req_valid, e_if_valid;
  logic [31:0] e_addr, e_pc, e_instr;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0: op = OP_R;
      3'd1: op = OP_IMM;
      3'd2: op = OP_LOAD;
      3'd3: op = OP_STORE;
      3'd4: op = OP_BRANCH;
      3'd5: op = OP_LUI;
      3'd6: op = OP_AUIPC;
      default: op = OP_JAL;
    endcase
    return {a[26:2] ^ 25'h15A5A5A, op};
  endfunction

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
  endtask

  task automatic model_reset();
    m_inflight.delete();
    m_buf.delete();
    m_pc  = 32'h0000_0000;
    m_wpc = 32'hFFFF_FFFC;
    m_epoch++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one cycle's inputs at the falling edge and compute what the outputs must be.
  task automatic drive_cycle(input logic rdy, input logic ifr, input logic redir,
                             input logic [31:0] rpc);
    @(negedge clk);
    imem_req_ready = rdy;
    if_ready       = ifr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (m_inflight.size() > 0 && m_inflight[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m_inflight[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    e_req_valid = !redir && ((m_inflight.size() + m_buf.size()) < DEPTH);
    e_addr      = m_pc;
    e_if_valid  = (m_buf.size() > 0) && !redir;
    e_pc        = (m_buf.size() > 0) ? m_buf[0].pc : 32'h0;
    e_instr     = (m_buf.size() > 0) ? m_buf[0].instr : 32'h0;
    #1;
  endtask

  // Apply the effect of the coming rising edge to the model.
  task automatic advance();
    req_t r;
    logic fire;
    fire = e_req_valid && imem_req_ready;
    if (e_if_valid && if_ready) void'(m_buf.pop_front());
    if (imem_rsp_valid) begin
      r = m_inflight.pop_front();
      if (!redirect_valid && r.epoch == m_epoch) m_buf.push_back('{r.addr, mem_word(r.addr)});
    end
    if (redirect_valid) begin
      m_buf.delete();
      m_epoch++;
      m_pc  = redirect_pc & ~32'h3;
      m_wpc = redirect_pc & ~32'h3;
    end else if (fire) begin
      m_inflight.push_back('{m_pc, m_epoch, cyc + lat_min + int'($urandom_range(0, lat_extra))});
      m_pc  = m_pc + 32'd4;
      m_wpc = m_wpc + 32'd4;
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset if_valid got %b want 0", if_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset imem_addr got %h want 0", imem_addr); end
    n_cmp++; if (wr_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL reset wrap_addr got %h want fffffffc", wr_addr); end
    n_cmp++; if ({if_instr, if_pc, if_opcode} !== 71'h0) begin n_bad++; $display("FAIL reset head got %h/%h/%h want 0", if_instr, if_pc, if_opcode); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    int first = -1;
    apply_reset();
    lat_min = 1; lat_extra = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (imem_req_valid !== e_req_valid) begin n_bad++; $display("FAIL seq req_valid cyc=%0d got %b want %b", i, imem_req_valid, e_req_valid); end
      n_cmp++; if (imem_addr !== e_addr) begin n_bad++; $display("FAIL seq imem_addr cyc=%0d got %h want %h", i, imem_addr, e_addr); end
      n_cmp++; if (if_valid !== e_if_valid) begin n_bad++; $display("FAIL seq if_valid cyc=%0d got %b want %b", i, if_valid, e_if_valid); end
      n_cmp++; if (if_pc !== e_pc || if_instr !== e_instr || if_opcode !== e_instr[6:0]) begin
        n_bad++; $display("FAIL seq head cyc=%0d got %h/%h/%h want %h/%h", i, if_pc, if_instr, if_opcode, e_pc, e_instr);
      end
      if (first < 0 && if_valid === 1'b1) first = i;
      advance();
    end
    n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL seq first_valid_cycle got %0d want 2", first); end
  endtask

  task automatic test_backpressure();
    int   accepted = 0;
    logic seen = 1'b0;
    logic [31:0] resumed = '0;
    apply_reset();
    lat_min = 1; lat_extra = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (imem_req_valid !== e_req_valid) begin n_bad++; $display("FAIL bp req_valid cyc=%0d got %b want %b", i, imem_req_valid, e_req_valid); end
      if (imem_req_valid === 1'b1) accepted++;
      advance();
    end
    n_cmp++; if (accepted !== 2) begin n_bad++; $display("FAIL bp accepted got %0d want 2", accepted); end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_valid !== e_if_valid || if_pc !== e_pc) begin n_bad++; $display("FAIL bp head cyc=%0d got %b/%h want %b/%h", i, if_valid, if_pc, e_if_valid, e_pc); end
      if (!seen && imem_req_valid === 1'b1) begin seen = 1'b1; resumed = imem_addr; end
      advance();
    end
    n_cmp++; if (!seen || resumed !== 32'h8) begin n_bad++; $display("FAIL bp resume_addr got %h (seen %b) want 00000008", resumed, seen); end
  endtask

  task automatic test_redirect();
    logic seen = 1'b0;
    apply_reset();
    lat_min = 3; lat_extra = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 1'b1, (i == 2), 32'h100);
      n_cmp++; if (imem_req_valid !== e_req_valid) begin n_bad++; $display("FAIL redir req_valid cyc=%0d got %b want %b", i, imem_req_valid, e_req_valid); end
      n_cmp++; if (imem_addr !== e_addr) begin n_bad++; $display("FAIL redir imem_addr cyc=%0d got %h want %h", i, imem_addr, e_addr); end
      n_cmp++; if (if_valid !== e_if_valid || if_pc !== e_pc || if_instr !== e_instr) begin
        n_bad++; $display("FAIL redir head cyc=%0d got %b/%h/%h want %b/%h/%h", i, if_valid, if_pc, if_instr, e_if_valid, e_pc, e_instr);
      end
      if (i == 3) begin
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL redir target_addr got %h want 00000100", imem_addr); end
      end
      if (i > 2 && !seen && if_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++; if (if_pc !== 32'h100) begin n_bad++; $display("FAIL redir first_pc got %h want 00000100", if_pc); end
      end
      advance();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL redir first_pc got none want 00000100"); end
  endtask

  task automatic test_redirect_with_rsp();
    logic done = 1'b0;
    logic redir;
    apply_reset();
    lat_min = 2; lat_extra = 0;
    for (int i = 0; i < 20; i++) begin
      redir = !done && m_buf.size() > 0 && m_inflight.size() > 0 && m_inflight[0].due <= cyc;
      drive_cycle(1'b1, 1'b1, redir, 32'h200);
      n_cmp++; if (if_valid !== e_if_valid || imem_req_valid !== e_req_valid) begin
        n_bad++; $display("FAIL redir_rsp valids cyc=%0d got %b/%b want %b/%b", i, if_valid, imem_req_valid, e_if_valid, e_req_valid);
      end
      n_cmp++; if (if_pc !== e_pc || if_instr !== e_instr || imem_addr !== e_addr) begin
        n_bad++; $display("FAIL redir_rsp data cyc=%0d got %h/%h/%h want %h/%h/%h", i, if_pc, if_instr, imem_addr, e_pc, e_instr, e_addr);
      end
      if (redir) done = 1'b1;
      advance();
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL redir_rsp setup got none want redirect with response"); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    lat_min = 1; lat_extra = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      advance();
    end
    n_cmp++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst full got %b/%b want 1/0", if_valid, imem_req_valid); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst immediate got %b/%b want 0/0", if_valid, imem_req_valid); end
    n_cmp++; if (imem_addr !== 32'h0 || if_pc !== 32'h0) begin n_bad++; $display("FAIL midrst state got %h/%h want 0/0", imem_addr, if_pc); end
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_valid !== e_if_valid || if_pc !== e_pc || if_instr !== e_instr || imem_addr !== e_addr) begin
        n_bad++; $display("FAIL midrst restart cyc=%0d got %b/%h/%h/%h want %b/%h/%h/%h", i, if_valid, if_pc, if_instr, imem_addr, e_if_valid, e_pc, e_instr, e_addr);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    int   issued = 0;
    logic seen = 1'b0;
    logic [31:0] second = 32'hDEAD_BEEF;
    apply_reset();
    lat_min = 1; lat_extra = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (wr_addr !== m_wpc) begin n_bad++; $display("FAIL wrap addr cyc=%0d got %h want %h", i, wr_addr, m_wpc); end
      if (wr_req_valid === 1'b1) begin
        if (issued == 1) second = wr_addr;
        issued++;
      end
      if (!seen && wr_if_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++; if (wr_if_pc !== 32'hFFFF_FFFC || wr_if_instr !== mem_word(32'h0) || wr_if_opcode !== OP_R) begin
          n_bad++; $display("FAIL wrap first_head got %h/%h/%h want fffffffc/%h/%h", wr_if_pc, wr_if_instr, wr_if_opcode, mem_word(32'h0), OP_R);
        end
      end
      advance();
    end
    n_cmp++; if (second !== 32'h0) begin n_bad++; $display("FAIL wrap second_addr got %h want 00000000", second); end
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h103);
    advance();
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h100 || wr_addr !== 32'h100) begin n_bad++; $display("FAIL wrap misaligned_redirect got %h/%h want 00000100", imem_addr, wr_addr); end
    advance();
  endtask

  task automatic test_random();
    logic redir;
    apply_reset();
    lat_min = 1; lat_extra = 2;
    for (int i = 0; i < 600; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      drive_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), redir, $urandom);
      n_cmp++; if (imem_req_valid !== e_req_valid) begin n_bad++; $display("FAIL rand req_valid cyc=%0d got %b want %b", i, imem_req_valid, e_req_valid); end
      n_cmp++; if (imem_addr !== e_addr) begin n_bad++; $display("FAIL rand imem_addr cyc=%0d got %h want %h", i, imem_addr, e_addr); end
      n_cmp++; if (if_valid !== e_if_valid) begin n_bad++; $display("FAIL rand if_valid cyc=%0d got %b want %b", i, if_valid, e_if_valid); end
      n_cmp++; if (if_pc !== e_pc || if_instr !== e_instr || if_opcode !== e_instr[6:0]) begin
        n_bad++; $display("FAIL rand head cyc=%0d got %h/%h/%h want %h/%h", i, if_pc, if_instr, if_opcode, e_pc, e_instr);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_with_rsp();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
